icmp_rx_buf_ctrl: RTL and testbench
===================================

ICMP_RX_BUF_CTRL -- requirements
Module: icmp_rx_buf_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, RAM address width; depth = 2**ADDR_WIDTH bytes.
REQ-002 Parameter RD_LATENCY, default 2, RAM read latency in clk cycles; legal values 1 and 2.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 rx_valid, rx_last, rx_err  in  1 each  byte strobe, final byte of frame, frame error flagged with rx_last.
REQ-006 rx_data  in  8  payload byte.
REQ-007 ram_wr_en  out  1; ram_wr_addr  out  ADDR_WIDTH; ram_wr_data  out  8  RAM write port.
REQ-008 ram_rd_addr  out  ADDR_WIDTH; ram_rd_data  in  8  RAM read port.
REQ-009 frame_ready  out  1  a complete good frame is held in the RAM.
REQ-010 frame_len  out  ADDR_WIDTH+1  byte count of the held frame.
REQ-011 tx_start  in  1  pulse; begin read-out of the held frame.
REQ-012 tx_valid, tx_last  out  1 each; tx_data  out  8  read-out stream, no backpressure.
REQ-013 drop_cnt  out  16  count of dropped frames, saturating.

Function
REQ-014 FSM states: IDLE, WRITE, DROP, HOLD, READ.
REQ-015 IDLE: on rx_valid, write byte to address 0 and go to WRITE; if rx_last is also set, apply the REQ-017 end-of-frame rules in the same cycle.
REQ-016 WRITE: each rx_valid drives ram_wr_en=1, ram_wr_data=rx_data, ram_wr_addr=write count; combinational, zero latency.
REQ-017 rx_last with rx_err=0 -> HOLD, frame_ready=1 next cycle, frame_len=bytes written; rx_last with rx_err=1 -> IDLE, drop_cnt+1.
REQ-018 Overflow: rx_valid when count = 2**ADDR_WIDTH -> no write, go to DROP.
REQ-019 DROP: discard bytes until rx_last, then go to IDLE and add 1 to drop_cnt.
REQ-020 Frame arriving in HOLD or READ: discard until its rx_last, then add 1 to drop_cnt; the held frame is unaffected.
REQ-021 HOLD: tx_start -> READ; frame_ready deasserts the cycle after tx_start.
REQ-022 READ: ram_rd_addr steps 0..frame_len-1, one address per cycle.
REQ-023 tx_valid/tx_last are the address-issue strobes delayed by RD_LATENCY; tx_data=ram_rd_data.
REQ-024 Delay tx_valid/tx_last/tx_data by RD_LATENCY; first tx_valid is RD_LATENCY+1 cycles after tx_start.
REQ-025 tx_valid is asserted for exactly frame_len consecutive cycles; tx_last is asserted with the final byte.
REQ-026 Return to IDLE the cycle after the final tx_valid.
REQ-027 tx_start outside HOLD is ignored.
REQ-028 A frame of length 2**ADDR_WIDTH is legal, and frame_len reports 2**ADDR_WIDTH.
REQ-029 drop_cnt saturates at 16'hFFFF.

Reset
REQ-030 While rst_n=0 at a rising clk edge, state <= IDLE.
REQ-031 Reset clears all counters, frame_len and drop_cnt to 0.
REQ-032 Reset forces all outputs to 0: ram_wr_en, frame_ready, tx_valid, tx_last, tx_data, ram_rd_addr.
REQ-033 Reset mid-frame or mid-read-out aborts the operation; no partial tx output follows and drop_cnt is not incremented.

Configuration
REQ-034 Macro ICMP_RX_CHKSUM_EN defined: add output chksum_ok (1 bit), the 16-bit one's-complement sum of the held frame.
REQ-035 Checksum rules: even-index bytes are high octets; an odd-length frame is padded with 8'h00.
REQ-036 chksum_ok is valid while frame_ready=1; it is 1 when the sum equals 16'hFFFF.
REQ-037 Macro undefined: no chksum_ok port and no checksum logic.

Verification
REQ-038 64-byte frame of bytes 0..63, no error -> frame_ready=1, frame_len=64. tx_start -> 64 tx_valid cycles, data 0..63, first one 3 cycles after tx_start (RD_LATENCY=2), tx_last on byte 63.
REQ-039 10-byte frame with rx_err on rx_last -> frame_ready stays 0, drop_cnt=1, no ram_wr_en after rx_last.
REQ-040 257-byte frame with ADDR_WIDTH=8 -> 256 writes, DROP state, drop_cnt+1, frame_ready=0. A following 256-byte frame is accepted with frame_len=256.
REQ-041 Second frame arrives during HOLD -> zero RAM writes, drop_cnt+1; read-out returns the first frame intact.
REQ-042 rst_n=0 for 1 cycle mid-READ -> tx_valid=0 next cycle, state IDLE, frame_ready=0, drop_cnt=0.
REQ-043 With ICMP_RX_CHKSUM_EN: 4-byte frame 45 00 BA FF -> chksum_ok=1; change the last byte to FE -> chksum_ok=0.

Source files
------------

// File: rtl/icmp_rx_buf_ctrl_if.sv
// Bundle of receive stream, RAM ports, frame status and read-out stream for icmp_rx_buf_ctrl.
// The chksum_ok signal exists only when ICMP_RX_CHKSUM_EN is defined.
interface icmp_rx_buf_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  rx_valid;
    logic                  rx_last;
    logic                  rx_err;
    logic [7:0]            rx_data;

    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [7:0]            ram_wr_data;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [7:0]            ram_rd_data;

    logic                  frame_ready;
    logic [ADDR_WIDTH:0]   frame_len;

    logic                  tx_start;
    logic                  tx_valid;
    logic                  tx_last;
    logic [7:0]            tx_data;

    logic [15:0]           drop_cnt;
`ifdef ICMP_RX_CHKSUM_EN
    logic                  chksum_ok;
`endif

    modport master (
        input  rx_valid, rx_last, rx_err, rx_data, ram_rd_data, tx_start,
        output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
        output frame_ready, frame_len, tx_valid, tx_last, tx_data, drop_cnt
`ifdef ICMP_RX_CHKSUM_EN
        , output chksum_ok
`endif
    );

    modport slave (
        output rx_valid, rx_last, rx_err, rx_data, ram_rd_data, tx_start,
        input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
        input  frame_ready, frame_len, tx_valid, tx_last, tx_data, drop_cnt
`ifdef ICMP_RX_CHKSUM_EN
        , input chksum_ok
`endif
    );
endinterface

// File: rtl/icmp_rx_buf_ctrl.sv
// Single-frame receive buffer: writes one good frame into an external RAM, then streams it out.
// Define ICMP_RX_CHKSUM_EN to add the one's-complement checksum status output chksum_ok.
module icmp_rx_buf_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    icmp_rx_buf_ctrl_if.master bus
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {IDLE, WRITE, DROP, HOLD, READ} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH:0]   wr_cnt;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic [15:0]           drop_q;
    logic                  ign_busy;
    logic [RD_LATENCY-1:0] v_pipe;
    logic [RD_LATENCY-1:0] l_pipe;

    logic                  rx_end;
    logic                  busy_st;
    logic                  full;
    logic                  wr_fire;
    logic                  good_end;
    logic                  drop_inc;
    logic                  issue;
    logic                  issue_last;
    logic                  read_done;
    logic                  ign_nxt;
    logic [ADDR_WIDTH:0]   wr_idx;

    // ign_busy tracks a frame being discarded while a held frame occupies the RAM.
    always_comb begin
        rx_end     = bus.rx_valid & bus.rx_last;
        busy_st    = (state == HOLD) || (state == READ);
        full       = (state == WRITE) && (wr_cnt == FULL_CNT);
        wr_idx     = (state == IDLE) ? '0 : wr_cnt;
        wr_fire    = bus.rx_valid && ((state == IDLE) || ((state == WRITE) && !full));
        good_end   = wr_fire && bus.rx_last && !bus.rx_err;
        drop_inc   = rx_end && ((((state == IDLE) || (state == WRITE)) && (bus.rx_err || full))
                                || (state == DROP) || busy_st);
        issue      = (state == READ) && (rd_cnt < len_q);
        issue_last = issue && (rd_cnt == (len_q - 1'b1));
        read_done  = v_pipe[RD_LATENCY-1] & l_pipe[RD_LATENCY-1];
        ign_nxt    = !rx_end && (ign_busy || bus.rx_valid);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, WRITE: begin
                if (bus.rx_valid) begin
                    if (full) begin
                        state_nxt = bus.rx_last ? IDLE : DROP;
                    end else if (bus.rx_last) begin
                        state_nxt = bus.rx_err ? IDLE : HOLD;
                    end else begin
                        state_nxt = WRITE;
                    end
                end
            end
            DROP: begin
                if (rx_end) state_nxt = IDLE;
            end
            HOLD: begin
                if (bus.tx_start) state_nxt = READ;
            end
            READ: begin
                // A frame still being discarded when read-out ends is finished off in DROP.
                if (read_done) state_nxt = ign_nxt ? DROP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            len_q    <= '0;
            rd_cnt   <= '0;
            drop_q   <= '0;
            ign_busy <= 1'b0;
            v_pipe   <= '0;
            l_pipe   <= '0;
        end else begin
            if (wr_fire) wr_cnt <= wr_idx + 1'b1;
            if (good_end) len_q <= wr_idx + 1'b1;
            if (state == HOLD) begin
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (drop_inc && (drop_q != '1)) drop_q <= drop_q + 1'b1;
            ign_busy  <= busy_st && ign_nxt;
            v_pipe[0] <= issue;
            l_pipe[0] <= issue_last;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                l_pipe[i] <= l_pipe[i-1];
            end
        end
    end

`ifdef ICMP_RX_CHKSUM_EN
    logic [15:0] chk_sum;
    logic [15:0] chk_term;
    logic [15:0] chk_base;
    logic [16:0] chk_raw;

    // Even byte indices are the high octet; end-around carry folded on every add.
    always_comb begin
        chk_term = wr_idx[0] ? {8'h00, bus.rx_data} : {bus.rx_data, 8'h00};
        chk_base = (state == IDLE) ? '0 : chk_sum;
        chk_raw  = {1'b0, chk_base} + {1'b0, chk_term};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_sum <= '0;
        end else if (wr_fire) begin
            chk_sum <= chk_raw[15:0] + {15'd0, chk_raw[16]};
        end
    end
`endif

    always_comb begin
        bus.ram_wr_en   = rst_n & wr_fire;
        bus.ram_wr_addr = wr_idx[ADDR_WIDTH-1:0];
        bus.ram_wr_data = bus.rx_data;
        bus.ram_rd_addr = rd_cnt[ADDR_WIDTH-1:0];
        bus.frame_ready = (state == HOLD);
        bus.frame_len   = len_q;
        bus.tx_valid    = v_pipe[RD_LATENCY-1];
        bus.tx_last     = l_pipe[RD_LATENCY-1];
        bus.tx_data     = v_pipe[RD_LATENCY-1] ? bus.ram_rd_data : '0;
        bus.drop_cnt    = drop_q;
`ifdef ICMP_RX_CHKSUM_EN
        bus.chksum_ok   = (state == HOLD) && (chk_sum == 16'hFFFF);
`endif
    end

endmodule

// File: tb/tb_icmp_rx_buf_ctrl.sv
// Bench for icmp_rx_buf_ctrl: directed and random frames checked against a frame-level model.
// Define ICMP_RX_CHKSUM_EN for both bench and design to cover chksum_ok.
module tb_icmp_rx_buf_ctrl;
    localparam int AW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] bytes_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icmp_rx_buf_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    icmp_rx_buf_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External RAM with LAT-cycle registered read.
    logic [7:0]  mem  [DEPTH];
    logic [7:0]  rd_q [LAT];
    int unsigned wr_total = 0;
    always @(posedge clk) begin
        if (bus.ram_wr_en) begin
            mem[bus.ram_wr_addr] <= bus.ram_wr_data;
            wr_total <= wr_total + 1;
        end
        rd_q[0] <= mem[bus.ram_rd_addr];
        for (int i = 1; i < LAT; i++) rd_q[i] <= rd_q[i-1];
    end
    assign bus.ram_rd_data = rd_q[LAT-1];

    int          checks   = 0;
    int          errors   = 0;
    bytes_t      held;
    bit          held_v   = 1'b0;
    int unsigned exp_drop = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int unsigned bump(input int unsigned d);
        return (d == 32'hFFFF) ? d : d + 1;
    endfunction

    function automatic bytes_t rand_frame(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic bit chk_model(input bytes_t q);
        int unsigned s = 0;
        for (int i = 0; i < q.size(); i += 2) begin
            s += {16'd0, q[i], (i + 1 < q.size()) ? q[i+1] : 8'h00};
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return s == 32'hFFFF;
    endfunction

    task automatic send_frame(input bytes_t q, input bit err, output int unsigned nwr);
        int unsigned w0;
        w0 = wr_total;
        for (int i = 0; i < q.size(); i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = q[i];
            bus.rx_last  = (i == q.size() - 1);
            bus.rx_err   = (i == q.size() - 1) && err;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
        bus.rx_err   = 1'b0;
        nwr = wr_total - w0;
    endtask

    task automatic frame_step(input string tag, input bytes_t q, input bit err);
        int unsigned nwr;
        int unsigned exp_wr;
        bit          accept;
        exp_wr = held_v ? 0 : ((q.size() > DEPTH) ? DEPTH : q.size());
        accept = !held_v && !err && (q.size() <= DEPTH);
        send_frame(q, err, nwr);
        if (accept) begin
            held   = q;
            held_v = 1'b1;
        end else begin
            exp_drop = bump(exp_drop);
        end
        check({tag, "_writes"}, nwr, exp_wr);
        check({tag, "_ready"}, 32'(bus.frame_ready), 32'(held_v));
        if (held_v) check({tag, "_len"}, 32'(bus.frame_len), held.size());
        check({tag, "_drop"}, 32'(bus.drop_cnt), exp_drop);
`ifdef ICMP_RX_CHKSUM_EN
        if (held_v) check({tag, "_chksum"}, 32'(bus.chksum_ok), 32'(chk_model(held)));
`endif
    endtask

    task automatic read_out(input string tag);
        bytes_t got;
        int     n;
        int     first_t;
        int     last_t;
        int     last_flag_t;
        int     nlast;
        int     bad;
        bit     exp_v;
        exp_v = held_v;
        n = exp_v ? held.size() : 0;
        first_t = -1; last_t = -1; last_flag_t = -1; nlast = 0; bad = 0;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        if (exp_v) check({tag, "_ready_after_start"}, 32'(bus.frame_ready), 0);
        for (int t = 1; t <= n + LAT + 6; t++) begin
            if (bus.tx_valid === 1'b1) begin
                got.push_back(bus.tx_data);
                if (first_t < 0) first_t = t;
                last_t = t;
            end
            if (bus.tx_last === 1'b1) begin
                nlast++;
                last_flag_t = t;
            end
            @(negedge clk);
        end
        check({tag, "_tx_count"}, 32'(got.size()), 32'(n));
        check({tag, "_tx_last_count"}, 32'(nlast), exp_v ? 1 : 0);
        if (exp_v) begin
            for (int i = 0; i < got.size() && i < n; i++) if (got[i] !== held[i]) bad++;
            check({tag, "_tx_data_bad"}, 32'(bad), 0);
            check({tag, "_first_valid_cycle"}, 32'(first_t), LAT + 1);
            check({tag, "_valid_span"}, 32'(last_t - first_t + 1), 32'(n));
            check({tag, "_last_on_final"}, 32'(last_flag_t), 32'(last_t));
            held_v = 1'b0;
            held.delete();
        end
        check({tag, "_ready_after_read"}, 32'(bus.frame_ready), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        bytes_t      f;
        bytes_t      f2;
        int unsigned nwr;
        int          nv;

        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
        bus.rx_err   = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_start = 1'b0;

        rst_n = 1'b0;
        idle(3);
        check("rst_frame_ready", 32'(bus.frame_ready), 0);
        check("rst_tx_valid",    32'(bus.tx_valid), 0);
        check("rst_tx_last",     32'(bus.tx_last), 0);
        check("rst_tx_data",     32'(bus.tx_data), 0);
        check("rst_ram_wr_en",   32'(bus.ram_wr_en), 0);
        check("rst_ram_rd_addr", 32'(bus.ram_rd_addr), 0);
        check("rst_frame_len",   32'(bus.frame_len), 0);
        check("rst_drop_cnt",    32'(bus.drop_cnt), 0);
        rst_n = 1'b1;
        idle(1);

        // 64-byte ramp frame, then read-out
        f.delete();
        for (int i = 0; i < 64; i++) f.push_back(8'(i));
        frame_step("f64", f, 1'b0);
        read_out("f64");

        // errored frame
        frame_step("err10", rand_frame(10), 1'b1);
        idle(1);

        // overflow then a full-depth frame
        frame_step("ovf257", rand_frame(257), 1'b0);
        frame_step("full256", rand_frame(256), 1'b0);
        read_out("full256");

        // second frame while one is held
        frame_step("holdA", rand_frame(20), 1'b0);
        frame_step("holdB", rand_frame(15), 1'b0);
        read_out("holdA");

        // tx_start with nothing held, then a one-byte frame
        read_out("idle_start");
        frame_step("one", rand_frame(1), 1'b0);
        read_out("one");

        // frame arriving and ending during read-out
        frame_step("rdA", rand_frame(30), 1'b0);
        f2 = rand_frame(5);
        exp_drop = bump(exp_drop);
        fork
            read_out("rdA");
            begin
                idle(4);
                send_frame(f2, 1'b0, nwr);
            end
        join
        check("rdB_writes", nwr, 0);
        check("rdB_drop", 32'(bus.drop_cnt), exp_drop);

        // frame that starts during read-out and outlasts it
        frame_step("spanA", rand_frame(4), 1'b0);
        f2 = rand_frame(40);
        exp_drop = bump(exp_drop);
        fork
            read_out("spanA");
            begin
                idle(2);
                send_frame(f2, 1'b0, nwr);
            end
        join
        check("spanB_writes", nwr, 0);
        check("spanB_drop", 32'(bus.drop_cnt), exp_drop);
        frame_step("after_span", rand_frame(8), 1'b0);
        read_out("after_span");

        // random frames against the model
        for (int it = 0; it < 30; it++) begin
            int n;
            bit err;
            n   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(240, 300)) : int'($urandom_range(1, 80));
            err = ($urandom_range(0, 4) == 0);
            frame_step("rnd", rand_frame(n), err);
            if ($urandom_range(0, 2) != 0) read_out("rnd");
            idle(int'($urandom_range(0, 3)));
        end
        if (held_v) read_out("rnd_flush");

`ifdef ICMP_RX_CHKSUM_EN
        f = '{8'h45, 8'h00, 8'hBA, 8'hFF};
        frame_step("ck_good", f, 1'b0);
        check("ck_good_ok", 32'(bus.chksum_ok), 1);
        read_out("ck_good");
        f[3] = 8'hFE;
        frame_step("ck_bad", f, 1'b0);
        check("ck_bad_ok", 32'(bus.chksum_ok), 0);
        read_out("ck_bad");
`endif

        // reset in the middle of read-out
        frame_step("rst_mid", rand_frame(40), 1'b0);
        bus.tx_start = 1'b1;
        idle(1);
        bus.tx_start = 1'b0;
        idle(6);
        check("rst_mid_streaming", 32'(bus.tx_valid), 1);
        rst_n = 1'b0;
        idle(1);
        check("rst_mid_tx_valid",    32'(bus.tx_valid), 0);
        check("rst_mid_frame_ready", 32'(bus.frame_ready), 0);
        check("rst_mid_drop_cnt",    32'(bus.drop_cnt), 0);
        check("rst_mid_rd_addr",     32'(bus.ram_rd_addr), 0);
        check("rst_mid_frame_len",   32'(bus.frame_len), 0);
        rst_n = 1'b1;
        held_v = 1'b0;
        held.delete();
        exp_drop = 0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.tx_valid === 1'b1) nv++;
            idle(1);
        end
        check("rst_mid_no_tail", 32'(nv), 0);
        frame_step("post_rst", rand_frame(12), 1'b0);
        read_out("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
